// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one combinational ALU, with a registered response slot per port.
// Optional feature: define ALU_ARB_RR_EN for round-robin tie-breaking (default is fixed priority, port 0 wins).
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [2:0]        rsp0_flags,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [2:0]        rsp1_flags,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_sign
);

  logic              elig0_s;
  logic              elig1_s;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              rsp0_valid_r;
  logic              rsp1_valid_r;
  logic [DATA_W-1:0] rsp0_result_r;
  logic [DATA_W-1:0] rsp1_result_r;
  logic [2:0]        rsp0_flags_r;
  logic [2:0]        rsp1_flags_r;
  logic [2:0]        alu_flags_s;

`ifdef ALU_ARB_RR_EN
  logic              last_r;
`endif

  assign alu_flags_s = {alu_carry, alu_zero, alu_sign};

  // Eligibility and grant; a full response slot may be freed by a same-cycle pop
  always_comb begin
    elig0_s = 1'b0;
    elig1_s = 1'b0;
    gnt0_s  = 1'b0;
    gnt1_s  = 1'b0;
    if (rst) begin
      elig0_s = 1'b0;
      elig1_s = 1'b0;
    end else begin
      elig0_s = req0_valid && (!rsp0_valid_r || rsp0_ready);
      elig1_s = req1_valid && (!rsp1_valid_r || rsp1_ready);
    end
    if (elig0_s && elig1_s) begin
`ifdef ALU_ARB_RR_EN
      gnt0_s = last_r;
      gnt1_s = !last_r;
`else
      gnt0_s = 1'b1;
      gnt1_s = 1'b0;
`endif
    end else begin
      gnt0_s = elig0_s;
      gnt1_s = elig1_s;
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;

  // ALU operand mux; idle cycles present all-zero operands
  always_comb begin
    alu_op = {OP_W{1'b0}};
    alu_a  = {DATA_W{1'b0}};
    alu_b  = {DATA_W{1'b0}};
    case ({gnt1_s, gnt0_s})
      2'b01: begin
        alu_op = req0_op;
        alu_a  = req0_a;
        alu_b  = req0_b;
      end
      2'b10: begin
        alu_op = req1_op;
        alu_a  = req1_a;
        alu_b  = req1_b;
      end
      default: begin
        alu_op = {OP_W{1'b0}};
        alu_a  = {DATA_W{1'b0}};
        alu_b  = {DATA_W{1'b0}};
      end
    endcase
  end

  // Port 0 response slot
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_r  <= 1'b0;
      rsp0_result_r <= {DATA_W{1'b0}};
      rsp0_flags_r  <= 3'b000;
    end else if (gnt0_s) begin
      rsp0_valid_r  <= 1'b1;
      rsp0_result_r <= alu_result;
      rsp0_flags_r  <= alu_flags_s;
    end else if (rsp0_valid_r && rsp0_ready) begin
      rsp0_valid_r  <= 1'b0;
    end else begin
      rsp0_valid_r  <= rsp0_valid_r;
    end
  end

  // Port 1 response slot
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp1_valid_r  <= 1'b0;
      rsp1_result_r <= {DATA_W{1'b0}};
      rsp1_flags_r  <= 3'b000;
    end else if (gnt1_s) begin
      rsp1_valid_r  <= 1'b1;
      rsp1_result_r <= alu_result;
      rsp1_flags_r  <= alu_flags_s;
    end else if (rsp1_valid_r && rsp1_ready) begin
      rsp1_valid_r  <= 1'b0;
    end else begin
      rsp1_valid_r  <= rsp1_valid_r;
    end
  end

`ifdef ALU_ARB_RR_EN
  // Most recently granted port; reset to 1 so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (gnt0_s) begin
      last_r <= 1'b0;
    end else if (gnt1_s) begin
      last_r <= 1'b1;
    end else begin
      last_r <= last_r;
    end
  end
`endif

  assign rsp0_valid  = rsp0_valid_r;
  assign rsp0_result = rsp0_result_r;
  assign rsp0_flags  = rsp0_flags_r;
  assign rsp1_valid  = rsp1_valid_r;
  assign rsp1_result = rsp1_result_r;
  assign rsp1_flags  = rsp1_flags_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: per-cycle vector table plus hand-written reset/tie sequences.
module tb_alu_arbiter;

  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_SUBU = 6'h23;
  localparam logic [5:0] OP_AND  = 6'h24;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [5:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [2:0]  rsp0_flags, rsp1_flags;
  logic [5:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_carry, alu_zero, alu_sign;
  logic [32:0] alu_wide;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(.DATA_W(32), .OP_W(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign)
  );

  // Small ALU model: carry is carry-out for add, borrow for subu
  always_comb begin
    alu_wide = 33'h0;
    case (alu_op)
      6'h20:   alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      6'h23:   alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      6'h24:   alu_wide = {1'b0, alu_a & alu_b};
      default: alu_wide = 33'h0;
    endcase
  end
  assign alu_result = alu_wide[31:0];
  assign alu_carry  = alu_wide[32];
  assign alu_zero   = (alu_wide[31:0] == 32'h0);
  assign alu_sign   = alu_wide[31];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic v0; logic [5:0] op0; logic [31:0] a0; logic [31:0] b0;
    logic v1; logic [5:0] op1; logic [31:0] a1; logic [31:0] b1;
    logic rr0; logic rr1;
    logic e_rdy0; logic e_rdy1; logic [5:0] e_op; logic [31:0] e_a; logic [31:0] e_b;
    logic e_v0; logic [31:0] e_r0; logic [2:0] e_f0;
    logic e_v1; logic [31:0] e_r1; logic [2:0] e_f1;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [5:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [5:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic rr0, input logic rr1);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp0_ready = rr0; rsp1_ready = rr1;
  endtask

  initial begin
    // Reset held with both ports requesting: nothing may be granted
    rst = 1'b1;
    drive(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, OP_ADD, 32'd2, 32'd2, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("rst rdy0", {31'h0, req0_ready}, 32'h0);
    chk("rst rdy1", {31'h0, req1_ready}, 32'h0);
    chk("rst alu_op", {26'h0, alu_op}, 32'h0);
    chk("rst v0", {31'h0, rsp0_valid}, 32'h0);
    chk("rst v1", {31'h0, rsp1_valid}, 32'h0);
    chk("rst r0", rsp0_result, 32'h0);
    chk("rst r1", rsp1_result, 32'h0);
    chk("rst f0", {29'h0, rsp0_flags}, 32'h0);
    chk("rst f1", {29'h0, rsp1_flags}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b1, 1'b1);

    vecs[0] = '{1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0, 32'h0, 3'b000};
    vecs[1] = '{1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, 6'h00, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b1, 1'b0, OP_ADD, 32'd5, 32'd7, 1'b1, 32'd12, 3'b000, 1'b0, 32'h0, 3'b000};
    vecs[2] = '{1'b0, 6'h00, 32'h0, 32'h0, 1'b1, OP_SUBU, 32'd3, 32'd3, 1'b1, 1'b1,
                1'b0, 1'b1, OP_SUBU, 32'd3, 32'd3, 1'b0, 32'd12, 3'b000, 1'b1, 32'h0, 3'b010};
    vecs[3] = '{1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 32'd12, 3'b000, 1'b0, 32'h0, 3'b010};
    vecs[4] = '{1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, OP_SUBU, 32'd1, 32'd2, 1'b1, 1'b1,
                1'b1, 1'b0, OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0, 3'b110, 1'b0, 32'h0, 3'b010};
    vecs[5] = '{1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, 6'h00, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b1, 1'b0, OP_ADD, 32'd5, 32'd7, 1'b1, 32'd12, 3'b000, 1'b0, 32'h0, 3'b010};
    vecs[6] = '{1'b1, OP_AND, 32'hF0F0_1234, 32'hFFFF_0000, 1'b1, OP_ADD, 32'd10, 32'd20, 1'b0, 1'b1,
                1'b0, 1'b1, OP_ADD, 32'd10, 32'd20, 1'b1, 32'd12, 3'b000, 1'b1, 32'd30, 3'b000};
    vecs[7] = '{1'b1, OP_AND, 32'hF0F0_1234, 32'hFFFF_0000, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 1'b0,
                1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b1, 32'd12, 3'b000, 1'b1, 32'd30, 3'b000};
    vecs[8] = '{1'b1, OP_AND, 32'hF0F0_1234, 32'hFFFF_0000, 1'b0, 6'h00, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b1, 1'b0, OP_AND, 32'hF0F0_1234, 32'hFFFF_0000, 1'b1, 32'hF0F0_0000, 3'b001, 1'b0, 32'd30, 3'b000};
    vecs[9] = '{1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b1, 1'b1,
                1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 32'hF0F0_0000, 3'b001, 1'b0, 32'd30, 3'b000};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0,
            vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].b1, vecs[i].rr0, vecs[i].rr1);
      #1;
      chk($sformatf("vec%0d rdy0", i), {31'h0, req0_ready}, {31'h0, vecs[i].e_rdy0});
      chk($sformatf("vec%0d rdy1", i), {31'h0, req1_ready}, {31'h0, vecs[i].e_rdy1});
      chk($sformatf("vec%0d alu_op", i), {26'h0, alu_op}, {26'h0, vecs[i].e_op});
      chk($sformatf("vec%0d alu_a", i), alu_a, vecs[i].e_a);
      chk($sformatf("vec%0d alu_b", i), alu_b, vecs[i].e_b);
      @(posedge clk); #1;
      chk($sformatf("vec%0d v0", i), {31'h0, rsp0_valid}, {31'h0, vecs[i].e_v0});
      chk($sformatf("vec%0d r0", i), rsp0_result, vecs[i].e_r0);
      chk($sformatf("vec%0d f0", i), {29'h0, rsp0_flags}, {29'h0, vecs[i].e_f0});
      chk($sformatf("vec%0d v1", i), {31'h0, rsp1_valid}, {31'h0, vecs[i].e_v1});
      chk($sformatf("vec%0d r1", i), rsp1_result, vecs[i].e_r1);
      chk($sformatf("vec%0d f1", i), {29'h0, rsp1_flags}, {29'h0, vecs[i].e_f1});
    end

    // Fill both slots, port 1 first so the last grant before reset is port 0
    @(negedge clk);
    drive(1'b0, 6'h00, 32'h0, 32'h0, 1'b1, OP_SUBU, 32'd9, 32'd4, 1'b1, 1'b0);
    #1 chk("fill rdy1", {31'h0, req1_ready}, 32'h1);
    @(negedge clk);
    drive(1'b1, OP_ADD, 32'd1, 32'd2, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 chk("fill rdy0", {31'h0, req0_ready}, 32'h1);
    @(posedge clk); #1;
    chk("fill v0", {31'h0, rsp0_valid}, 32'h1);
    chk("fill v1", {31'h0, rsp1_valid}, 32'h1);
    chk("fill r1", rsp1_result, 32'd5);

    // One-cycle reset pulse while both slots are full and both ports request
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, OP_ADD, 32'd1, 32'd2, 1'b1, OP_SUBU, 32'd9, 32'd4, 1'b1, 1'b1);
    #1;
    chk("pulse rdy0", {31'h0, req0_ready}, 32'h0);
    chk("pulse rdy1", {31'h0, req1_ready}, 32'h0);
    @(posedge clk); #1;
    chk("pulse v0", {31'h0, rsp0_valid}, 32'h0);
    chk("pulse v1", {31'h0, rsp1_valid}, 32'h0);
    chk("pulse r0", rsp0_result, 32'h0);

    // Continuous tie: alternation under round-robin, port 0 only under fixed priority
    for (int k = 0; k < 4; k++) begin
      logic e0;
      @(negedge clk);
      rst = 1'b0;
`ifdef ALU_ARB_RR_EN
      e0 = (k % 2 == 0);
`else
      e0 = 1'b1;
`endif
      #1;
      chk($sformatf("tie%0d rdy0", k), {31'h0, req0_ready}, {31'h0, e0});
      chk($sformatf("tie%0d rdy1", k), {31'h0, req1_ready}, {31'h0, !e0});
      @(posedge clk); #1;
      chk($sformatf("tie%0d v0", k), {31'h0, rsp0_valid}, {31'h0, e0});
      chk($sformatf("tie%0d v1", k), {31'h0, rsp1_valid}, {31'h0, !e0});
      if (e0) chk($sformatf("tie%0d r0", k), rsp0_result, 32'd3);
      else    chk($sformatf("tie%0d r1", k), rsp1_result, 32'd5);
    end

    // Idle with no consumers: zero ALU drive, responses held
    @(negedge clk);
    drive(1'b0, OP_ADD, 32'h55, 32'h66, 1'b0, OP_SUBU, 32'h77, 32'h88, 1'b0, 1'b0);
    #1;
    chk("idle alu_op", {26'h0, alu_op}, 32'h0);
    chk("idle alu_a", alu_a, 32'h0);
    chk("idle alu_b", alu_b, 32'h0);
    @(posedge clk); #1;
`ifdef ALU_ARB_RR_EN
    chk("idle v0", {31'h0, rsp0_valid}, 32'h0);
    chk("idle v1", {31'h0, rsp1_valid}, 32'h1);
`else
    chk("idle v0", {31'h0, rsp0_valid}, 32'h1);
    chk("idle v1", {31'h0, rsp1_valid}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
